// File: rtl/cond_pkg.sv
// Shared constants and helpers for the input conditioner and its synchronizer.
package cond_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;
  localparam int CNT_W_DEF       = 8;

  // Debounce counter width: enough to hold DEBOUNCE_CYCLES-1, never narrower than 1 bit.
  function automatic int deb_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction
endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; q is the last flop of the chain.
module sync_chain
  import cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces one raw input, then derives rise/fall pulses, a toggle and a rise counter.
module input_conditioner
  import cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             toggle,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);

  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_next;
  logic          rise_evt;
  logic          fall_evt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (s)
  );

  // A sample that matches level, or a disabled cycle, throws away any partial count.
  always_comb begin
    cnt_next   = '0;
    level_next = level;
    rise_evt   = 1'b0;
    fall_evt   = 1'b0;
    if (en && (s != level)) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_next = s;
        rise_evt   = s;
        fall_evt   = ~s;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      toggle   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_evt;
      fall  <= fall_evt;
      if (rise_evt) begin
        toggle <= ~toggle;
      end
      // clr beats a simultaneous rise: that event is not counted.
      if (clr) begin
        edge_cnt <= '0;
      end else if (rise_evt) begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random din/en/clr against a run-length model.
module tb_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          din = 1'b0;
  logic          en = 1'b1;
  logic          clr = 1'b0;
  logic          level, rise, fall, toggle;
  logic [CW-1:0] edge_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_sq[$];
  bit m_lvl, m_rise, m_fall, m_tog;
  int m_cnt, m_run;

  input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .en       (en),
    .clr      (clr),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .toggle   (toggle),
    .edge_cnt (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sq.delete();
    for (int i = 0; i < SYNC; i++) m_sq.push_back(1'b0);
    m_lvl = 0; m_rise = 0; m_fall = 0; m_tog = 0; m_cnt = 0; m_run = 0;
  endtask

  // One clock edge of the model: s is din delayed SYNC edges; level flips once the
  // enabled synchronized input has disagreed with it for DEB consecutive edges.
  task automatic model_edge();
    bit s;
    if (!reset) begin
      model_reset();
      return;
    end
    s = m_sq.pop_front();
    m_sq.push_back(din);
    m_rise = 0;
    m_fall = 0;
    if (!en || s == m_lvl) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl  = s;
        m_rise = s;
        m_fall = !s;
        m_run  = 0;
      end
    end
    if (m_rise) m_tog = !m_tog;
    if (clr) m_cnt = 0;
    else if (m_rise) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".level"}, 32'(level), 32'(m_lvl));
    check_eq({tag, ".rise"}, 32'(rise), 32'(m_rise));
    check_eq({tag, ".fall"}, 32'(fall), 32'(m_fall));
    check_eq({tag, ".toggle"}, 32'(toggle), 32'(m_tog));
    check_eq({tag, ".edge_cnt"}, 32'(edge_cnt), 32'(m_cnt));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int rises;
    model_reset();

    // 1: reset holds everything at 0 even with din high, then full latency
    din = 1'b1;
    steps("rst_hold", 3);
    check_eq("rst_zero", {level, rise, fall, toggle, edge_cnt}, 0);
    reset = 1'b1;
    steps("t1", 5);
    check_eq("t1_lvl_pre", 32'(level), 0);
    step("t1");
    check_eq("t1_lvl6", 32'(level), 1);
    check_eq("t1_rise6", 32'(rise), 1);
    check_eq("t1_tog6", 32'(toggle), 1);
    check_eq("t1_cnt6", 32'(edge_cnt), 1);
    step("t1");
    check_eq("t1_rise7", 32'(rise), 0);

    // 3: falling edge leaves toggle and count alone
    din = 1'b0;
    steps("t3", 5);
    check_eq("t3_lvl_pre", 32'(level), 1);
    step("t3");
    check_eq("t3_fall6", {level, fall, toggle, edge_cnt}, {1'b0, 1'b1, 1'b1, 8'd1});
    steps("t3", 4);

    // 2: a 3-cycle glitch is rejected, a 4-cycle pulse is accepted
    din = 1'b1; steps("t2a", 3);
    din = 1'b0; steps("t2a", 10);
    check_eq("t2_glitch_lvl", 32'(level), 0);
    check_eq("t2_glitch_cnt", 32'(edge_cnt), 1);
    din = 1'b1; steps("t2b", 4);
    din = 1'b0; steps("t2b", 3);
    check_eq("t2_pulse4_lvl", 32'(level), 1);
    steps("t2b", 10);
    check_eq("t2_back_low", 32'(level), 0);

    // 4: 256 rises wrap the count back to the value before them; then clr meets a rise
    clr = 1'b1; step("t4_clr"); clr = 1'b0;
    check_eq("t4_cleared", 32'(edge_cnt), 0);
    rises = 0;
    for (int i = 0; i < 256; i++) begin
      din = 1'b1; steps("t4", 6);
      din = 1'b0; steps("t4", 6);
      rises++;
      if (rises == 255) check_eq("t4_255", 32'(edge_cnt), 255);
    end
    check_eq("t4_wrap", 32'(edge_cnt), 0);
    din = 1'b1; steps("t4_pre", 3);
    check_eq("t4_pre_cnt", 32'(edge_cnt), 0);
    clr = 1'b1; din = 1'b1; steps("t4b", 0);
    clr = 1'b0;
    // bring count to a non-zero value first so the clr effect is visible
    steps("t4b", 3);
    din = 1'b0; steps("t4b", 8);
    check_eq("t4_cnt_one", 32'(edge_cnt), 1);
    din = 1'b1; steps("t4c", 5);
    clr = 1'b1;
    step("t4c");
    clr = 1'b0;
    check_eq("t4_clr_rise", 32'(rise), 1);
    check_eq("t4_clr_cnt", 32'(edge_cnt), 0);
    check_eq("t4_clr_tog", 32'(toggle), 32'(m_tog));
    din = 1'b0; steps("t4c", 8);

    // 5: enable gating holds level, then 4 enabled edges are needed
    en = 1'b0; din = 1'b1; steps("t5", 20);
    check_eq("t5_gated", 32'(level), 0);
    en = 1'b1; steps("t5", 3);
    check_eq("t5_en3", 32'(level), 0);
    step("t5");
    check_eq("t5_en4", 32'(level), 1);
    din = 1'b0; steps("t5", 8);

    // 6: async reset two cycles into the count, between edges
    din = 1'b1; steps("t6", 4);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("t6_async");
    check_eq("t6_zero", {level, rise, fall, toggle, edge_cnt}, 0);
    steps("t6_hold", 2);
    reset = 1'b1;
    steps("t6", 5);
    check_eq("t6_lvl5", 32'(level), 0);
    step("t6");
    check_eq("t6_lvl6", 32'(level), 1);

    // random din runs with occasional en drops and clr pulses
    for (int i = 0; i < 500; i++) begin
      din = 1'($urandom_range(0, 1));
      for (int k = 0, n = $urandom_range(1, 8); k < n; k++) begin
        en  = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 19) == 0);
        step("rnd");
      end
    end
    en = 1'b1; clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Conditions one asynchronous, bouncy input into a clean, clock-domain-safe level for the register and flip-flop stages downstream. The block contains three functions:
- a multi-flop synchronizer;
- a consecutive-sample debouncer;
- edge-pulse, toggle and edge-count outputs.

It sits directly upstream of the storage stages and drives their D inputs and enables.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal values are 2 or more.
DEBOUNCE_CYCLES, 4, number of consecutive cycles the synchronized input must differ from level before level updates; legal values are 1 or more.
CNT_W, 8, width of edge_cnt.

Ports:
clk  input  1  rising-edge clock, single clock domain.
reset  input  1  asynchronous, active-low reset; all state clears while reset=0.
din  input  1  raw asynchronous input.
en  input  1  debounce enable; synchronous.
clr  input  1  synchronous clear of edge_cnt.
level  output  1  debounced, synchronized level.
rise  output  1  one-cycle pulse when level goes 0->1.
fall  output  1  one-cycle pulse when level goes 1->0.
toggle  output  1  flips on every rise pulse.
edge_cnt  output  CNT_W  count of rise events; wraps modulo 2^CNT_W.

Behaviour:
Reset:
- reset=0 asynchronously clears the sync chain, debounce counter, level, rise, fall, toggle and edge_cnt to 0, with no clock needed.
- The first update after release occurs on the first rising clk edge with reset=1.

Synchronizer:
- din passes through SYNC_STAGES flops in series. s is the last flop's output.
- The chain runs regardless of en.

Debounce counter:
- The counter C has width max(1, clog2(DEBOUNCE_CYCLES)).
- If en=0, C<=0 and level is held. No pulses are produced.
- Else if s==level, C<=0.
- Else if C==DEBOUNCE_CYCLES-1, then level<=s and C<=0. In the same edge, rise<=s or fall<=~s.
- Else C<=C+1.
- Any single-cycle return of s to the level value restarts the count from 0.

Pulses:
- rise and fall are registered. Each is high for exactly the one cycle in which the new level first appears.
- Otherwise rise and fall are 0. They are never high at the same time.

Latency:
- din changes and then stays stable. level updates on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the change. With defaults this is 6 edges.
- With DEBOUNCE_CYCLES=1 the latency is SYNC_STAGES+1.

Toggle:
- toggle<=~toggle on each edge where rise is set.
- clr does not affect toggle.

Edge count:
- edge_cnt increments on each edge where rise is set, wrapping from 2^CNT_W-1 to 0.
- clr=1 forces edge_cnt<=0. If clr and a rise event occur on the same edge, clr wins: edge_cnt=0 and the event is not counted, while rise and toggle still update normally.
- fall events do not count.

Other rules:
- en deasserted mid-count discards partial progress. Counting restarts from 0 on the first edge with en=1.
- Reset asserted mid-count or mid-pulse clears everything immediately, and a pulse in progress is truncated.
- No combinational path from any input to any output.

Decomposition:
Shared package cond_pkg holds:
- default parameter constants: SYNC_STAGES_DEF=2, DEBOUNCE_DEF=4, CNT_W_DEF=8;
- a clog2-based width function for the debounce counter.

One natural sub-module: sync_chain. It is parameterised by SYNC_STAGES, has clk, active-low async reset, input d and output q, and is reused for other asynchronous inputs. Debounce, pulse, toggle and count logic live in input_conditioner.

Test Plan:
1. Reset and rise: reset=0 with din=1 -> all outputs 0. Release reset and hold din=1 -> level=1 on the 6th edge; rise=1 for that one cycle only; toggle=1; edge_cnt=1.
2. Glitch rejection: level=0; din=1 for 3 cycles, then 0 -> level stays 0 and rise never asserts. Repeat with 4 high cycles -> level=1 after the chain delay.
3. Falling edge: level=1; din=0 held -> fall=1 for one cycle on the 6th edge; level=0; edge_cnt and toggle unchanged.
4. Wrap and clear: generate 256 clean rise events with CNT_W=8 -> edge_cnt goes 255->0. Then assert clr on the same edge as a rise pulse -> edge_cnt=0 and toggle still flips.
5. Enable gating: en=0; din 0->1 held for 20 cycles -> level stays 0. Raise en -> level=1 on the 4th edge with en=1.
6. Async reset mid-count: din 0->1; assert reset=0 two cycles into the debounce count, between clock edges -> all outputs 0 immediately. Release reset with din=1 -> full 6-edge latency before level=1.
